// File: rtl/acl_spi_shifter.sv
// -----------------------------------------------------------------------------
// acl_spi_shifter
//
// Byte-level SPI mode-0 shift engine (CPOL=0, CPHA=0) for the ACL accelerometer
// link. A one-cycle `transmit` pulse in IDLE latches `tx_data`. The byte is then
// shifted out MSB-first on `mosi` while 8 bits are captured from `miso` on the
// sclk rising edges. Completion is flagged by a one-cycle `done` pulse, which
// the downstream slave-select stage uses to release `ss`.
//
// Parameters:
//   CLK_DIV   system-clock cycles per sclk half-period (2..255)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   transmit  in   start request, sampled only in IDLE
//   tx_data   in   [7:0] byte to send, latched on acceptance
//   miso      in   serial data from the ACL
//   sclk      out  SPI clock, idles low
//   mosi      out  serial data to the ACL
//   rx_data   out  [7:0] captured byte, valid from the done cycle
//   busy      out  high from the cycle after acceptance through the done cycle
//   done      out  one-cycle completion pulse
//
// Optional build macro:
//   ACL_SPI_LOOPBACK_EN  when defined, the receive shifter samples the internal
//                        mosi register instead of the miso port (board
//                        self-test; rx_data returns the transmitted byte).
// -----------------------------------------------------------------------------
module acl_spi_shifter #(
    parameter int CLK_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic [7:0] tx_data,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_tx, w_tx_nxt;
    logic [7:0]       r_rx, w_rx_nxt;
    logic [7:0]       r_rx_data, w_rx_data_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_mosi, w_mosi_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_sin;

`ifdef ACL_SPI_LOOPBACK_EN
    // Self-test: capture our own outgoing bit; the ACL line is not used.
    assign w_sin = r_mosi;
`else
    assign w_sin = miso;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_bit_nxt     = r_bit;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_rx_data_nxt = r_rx_data;
        w_sclk_nxt    = r_sclk;
        w_mosi_nxt    = r_mosi;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                w_sclk_nxt = 1'b0;
                if (transmit) begin
                    w_tx_nxt    = tx_data;
                    w_mosi_nxt  = tx_data[7];
                    w_div_nxt   = '0;
                    w_bit_nxt   = 3'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div_nxt  = '0;
                    w_sclk_nxt = ~r_sclk;
                    if (!r_sclk) begin
                        // Rising toggle: sample the incoming bit.
                        w_rx_nxt = {r_rx[6:0], w_sin};
                    end else if (r_bit != 3'd7) begin
                        // Falling toggle: present the next outgoing bit.
                        w_bit_nxt  = r_bit + 3'd1;
                        w_tx_nxt   = {r_tx[6:0], 1'b0};
                        w_mosi_nxt = r_tx[6];
                    end else begin
                        // Last falling toggle: results become visible in the
                        // single FINISH cycle, which is also the done cycle.
                        w_mosi_nxt    = 1'b0;
                        w_rx_data_nxt = r_rx;
                        w_done_nxt    = 1'b1;
                        w_state_nxt   = FINISH;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            FINISH: begin
                // transmit is deliberately not looked at here.
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_busy_nxt  = 1'b0;
                w_sclk_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_div     <= '0;
            r_bit     <= 3'd0;
            r_tx      <= 8'h00;
            r_rx      <= 8'h00;
            r_rx_data <= 8'h00;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_sclk    <= w_sclk_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign rx_data = r_rx_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_acl_spi_shifter.sv
module tb_acl_spi_shifter;

    localparam int N    = 4;
    localparam int LAST = 16 * N + 1;
`ifdef ACL_SPI_LOOPBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso = 1'b0;
    logic       sclk, mosi, busy, done;
    logic [7:0] rx_data;

    logic       transmit2 = 1'b0;
    logic [7:0] tx_data2 = 8'h00;
    logic       miso2 = 1'b0;
    logic       sclk2, mosi2, busy2, done2;
    logic [7:0] rx_data2;

    int errors = 0;
    int checks = 0;
    logic run_chk = 1'b0;

    logic [7:0] slave_byte = 8'h00;

    always #5 clk = ~clk;

    acl_spi_shifter #(.CLK_DIV(N)) dut (
        .clk(clk), .rst(rst), .transmit(transmit), .tx_data(tx_data),
        .miso(miso), .sclk(sclk), .mosi(mosi), .rx_data(rx_data),
        .busy(busy), .done(done)
    );

    acl_spi_shifter #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .transmit(transmit2), .tx_data(tx_data2),
        .miso(miso2), .sclk(sclk2), .mosi(mosi2), .rx_data(rx_data2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: m_k is the cycle offset since acceptance
    // (0 = idle, 1..16N = shifting, 16N+1 = the done cycle).
    int         m_k = 0;
    logic [7:0] m_tx = 8'h00;
    logic [7:0] m_sl = 8'h00;
    logic [7:0] m_rxd = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k   <= 0;
            m_rxd <= 8'h00;
        end else if (m_k == 0) begin
            if (transmit) begin
                m_k  <= 1;
                m_tx <= tx_data;
                m_sl <= slave_byte;
            end
        end else if (m_k == LAST) begin
            m_k <= 0;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == LAST) m_rxd <= LOOP ? m_tx : m_sl;
        end
    end

    // Slave: presents bit b of its byte during bit period b; it changes
    // right after each sclk falling edge.
    always @(negedge clk) begin
        if (LOOP)
            miso <= 1'b0;
        else if (m_k >= 1 && m_k <= 16 * N)
            miso <= m_sl[7 - ((m_k - 1) / (2 * N))];
        else
            miso <= m_sl[7];
    end

    always @(negedge clk) begin
        logic e_sclk, e_mosi;
        if (run_chk) begin
            if (rst) begin
                chk("rst_sclk", sclk, 0);
                chk("rst_mosi", mosi, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rx", rx_data, 0);
            end else begin
                e_sclk = 1'b0;
                e_mosi = 1'b0;
                if (m_k >= 1 && m_k <= 16 * N) begin
                    e_sclk = (((m_k - 1) / N) % 2) == 1;
                    e_mosi = m_tx[7 - ((m_k - 1) / (2 * N))];
                end
                chk("sclk", sclk, e_sclk);
                chk("mosi", mosi, e_mosi);
                chk("busy", busy, m_k >= 1);
                chk("done", done, m_k == LAST);
                chk("rx_data", rx_data, m_rxd);
            end
        end
    end

    // Cumulative monitor of mosi at sclk rising edges and of done pulses.
    logic [7:0] mon_bits = 8'h00;
    int         mon_rises = 0;
    int         mon_dones = 0;
    logic       mon_prev = 1'b0;

    always @(negedge clk) begin
        if (sclk === 1'b1 && mon_prev === 1'b0) begin
            mon_bits  <= {mon_bits[6:0], mosi};
            mon_rises <= mon_rises + 1;
        end
        if (done === 1'b1) mon_dones <= mon_dones + 1;
        mon_prev <= sclk;
    end

    int t_rises, t_dones;

    task automatic xfer(input logic [7:0] tx, input logic [7:0] sl, input int inj,
                        input int rcyc, output int lat);
        int r0, d0;
        @(posedge clk); #1;
        slave_byte = sl;
        tx_data    = tx;
        transmit   = 1'b1;
        r0 = mon_rises;
        d0 = mon_dones;
        @(posedge clk); #1;
        transmit = 1'b0;
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk); #1;
            transmit = (c == inj);
            if (c == inj) tx_data = 8'hFF;
            if (c == rcyc) begin
                rst = 1'b1;
                #1;
                chk("async_rst_sclk", sclk, 0);
                chk("async_rst_busy", busy, 0);
                chk("async_rst_rx", rx_data, 0);
            end
            if (rcyc != 0 && c == rcyc + 3) rst = 1'b0;
            if (done === 1'b1 && lat == 0) lat = c;
            if (rcyc == 0 && lat != 0) break;
            if (rcyc != 0 && c == rcyc + 5) break;
        end
        t_rises = mon_rises - r0;
        t_dones = mon_dones - d0;
    endtask

    task automatic run_div2();
        logic [7:0] bits;
        int rises, first, lastr, lat;
        logic prev;
        @(posedge clk); #1;
        tx_data2  = 8'h81;
        transmit2 = 1'b1;
        @(posedge clk); #1;
        transmit2 = 1'b0;
        bits = 8'h00; rises = 0; first = 0; lastr = 0; lat = 0; prev = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (sclk2 === 1'b1 && prev === 1'b0) begin
                bits = {bits[6:0], mosi2};
                rises++;
                if (rises == 1) first = c;
                lastr = c;
            end
            prev = sclk2;
            if (done2 === 1'b1 && lat == 0) lat = c;
        end
        chk("div2_done_latency", lat, 33);
        chk("div2_mosi_bits", bits, 8'h81);
        chk("div2_rises", rises, 8);
        chk("div2_first_rise", first, 3);
        chk("div2_sclk_period", lastr - first, 28);
        chk("div2_rx", rx_data2, LOOP ? 8'h81 : 8'h00);
        chk("div2_sclk_idle", sclk2, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #1 rst = 1'b1;
        run_chk = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_sclk", sclk, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rx", rx_data, 8'h00);
        #1 rst = 1'b0;

        // Basic transfer
        xfer(8'hA5, 8'h3C, 0, 0, lat);
        chk("basic_latency", lat, 65);
        chk("basic_mosi_bits", mon_bits, 8'hA5);
        chk("basic_rises", t_rises, 8);
        chk("basic_rx", rx_data, LOOP ? 8'hA5 : 8'h3C);
        chk("basic_dones", t_dones, 1);
        @(negedge clk);
        chk("basic_done_width", done, 0);
        chk("basic_sclk_after", sclk, 0);

        // Busy rejection
        xfer(8'h0B, 8'h96, 20, 0, lat);
        repeat (6) @(negedge clk);
        chk("busy_latency", lat, 65);
        chk("busy_mosi_bits", mon_bits, 8'h0B);
        chk("busy_rises", t_rises, 8);
        chk("busy_rx", rx_data, LOOP ? 8'h0B : 8'h96);
        chk("busy_no_restart", busy, 0);

        // Back-to-back
        xfer(8'h0A, 8'h55, 0, 0, lat);
        chk("b2b1_latency", lat, 65);
        chk("b2b1_rx", rx_data, LOOP ? 8'h0A : 8'h55);
        xfer(8'h08, 8'hAA, 0, 0, lat);
        chk("b2b2_latency", lat, 65);
        chk("b2b2_mosi_bits", mon_bits, 8'h08);
        chk("b2b2_rx", rx_data, LOOP ? 8'h08 : 8'hAA);

        // Reset mid-operation, then a normal transfer
        xfer(8'hC0, 8'h77, 0, 30, lat);
        chk("rst_no_done", t_dones, 0);
        chk("rst_idle_busy", busy, 0);
        xfer(8'h5A, 8'hE7, 0, 0, lat);
        chk("after_rst_latency", lat, 65);
        chk("after_rst_mosi_bits", mon_bits, 8'h5A);
        chk("after_rst_rx", rx_data, LOOP ? 8'h5A : 8'hE7);

        // Minimum divider
        run_div2();

`ifdef ACL_SPI_LOOPBACK_EN
        xfer(8'hC3, 8'h00, 0, 0, lat);
        chk("loop_rx", rx_data, 8'hC3);
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
